// File: rtl/sap1_pkg.sv
// ----------------------------------------------------------------------------
// sap1_pkg
// Shared definitions for the SAP-1 controller/sequencer:
//   - opcode constants for the five defined instructions
//   - T-state index enum (bit position in the one-hot ring, T1 = bit 0)
//   - control_word_t, the 12-bit control word in datapath bit order
//   - CW_IDLE, the control word with every signal at its inactive level
// ----------------------------------------------------------------------------
package sap1_pkg;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic [2:0] {
      T1 = 3'd0,
      T2 = 3'd1,
      T3 = 3'd2,
      T4 = 3'd3,
      T5 = 3'd4,
      T6 = 3'd5
   } t_idx_e;

   // MSB first: Cp Ep Lm_bar CE_bar Li_bar Ei_bar La_bar Ea Su Eu Lb_bar Lo_bar
   typedef struct packed {
      logic Cp;
      logic Ep;
      logic Lm_bar;
      logic CE_bar;
      logic Li_bar;
      logic Ei_bar;
      logic La_bar;
      logic Ea;
      logic Su;
      logic Eu;
      logic Lb_bar;
      logic Lo_bar;
   } control_word_t;

   // Active-high signals low, active-low signals high.
   localparam control_word_t CW_IDLE = 12'b0011_1110_0011;

endpackage

// File: rtl/controller_sequencer_if.sv
// ----------------------------------------------------------------------------
// controller_sequencer_if
// Bundles the opcode input, the T-state output, the 12 control lines and the
// halt request of the SAP-1 controller/sequencer.
//   master : the controller (consumes instruction_bus, drives everything else)
//   slave  : the datapath side (drives instruction_bus, observes the rest)
// ----------------------------------------------------------------------------
interface controller_sequencer_if #(
   parameter int INSTRUCTION_WIDTH = 4,
   parameter int RING_LENGTH       = 6
);
   logic [INSTRUCTION_WIDTH-1:0] instruction_bus;
   logic [RING_LENGTH-1:0]       t_state;
   logic Cp;
   logic Ep;
   logic Lm_bar;
   logic CE_bar;
   logic Li_bar;
   logic Ei_bar;
   logic La_bar;
   logic Ea;
   logic Su;
   logic Eu;
   logic Lb_bar;
   logic Lo_bar;
   logic hlt;

   modport master (
      input  instruction_bus,
      output t_state, Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar,
             La_bar, Ea, Su, Eu, Lb_bar, Lo_bar, hlt
   );

   modport slave (
      output instruction_bus,
      input  t_state, Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar,
             La_bar, Ea, Su, Eu, Lb_bar, Lo_bar, hlt
   );
endinterface

// File: rtl/ring_counter.sv
// ----------------------------------------------------------------------------
// ring_counter
// One-hot T-state ring for the SAP-1 sequencer. Rotates left on each falling
// clock edge unless hold is high; an asynchronous active-low clear forces T1.
// Ports:
//   clk      in   clock (state changes on falling edge)
//   clr_bar  in   asynchronous active-low clear to T1
//   hold     in   freeze the ring (driven by the halt request)
//   t_state  out  one-hot current T-state, bit 0 = T1
// ----------------------------------------------------------------------------
module ring_counter #(
   parameter int RING_LENGTH = 6
) (
   input  logic                   clk,
   input  logic                   clr_bar,
   input  logic                   hold,
   output logic [RING_LENGTH-1:0] t_state
);

   always_ff @(negedge clk or negedge clr_bar) begin
      if (!clr_bar) begin
         t_state <= RING_LENGTH'(1);
      end else if (!hold) begin
         t_state <= {t_state[RING_LENGTH-2:0], t_state[RING_LENGTH-1]};
      end
   end

endmodule

// File: rtl/controller_sequencer.sv
// ----------------------------------------------------------------------------
// controller_sequencer
// SAP-1 control unit. A 6-state one-hot ring (T1..T6) sequences fetch
// (T1-T3) and execute (T4-T6); the control word is decoded combinationally
// from the T-state and the opcode. State changes on the falling edge so the
// control word is settled half a period before the rising edge at which the
// datapath loads. HLT in T4 raises hlt, and the next falling edge latches a
// halted flag that freezes the ring until clr_bar is asserted.
// Ports:
//   clk      in     system clock
//   clr_bar  in     asynchronous active-low reset
//   ctrl     master instruction_bus in; t_state, 12 control lines, hlt out
// RING_LENGTH is fixed at 6 for SAP-1; other values are not supported.
// ----------------------------------------------------------------------------
module controller_sequencer
   import sap1_pkg::*;
#(
   parameter int INSTRUCTION_WIDTH = 4,
   parameter int RING_LENGTH       = 6
) (
   input  logic                   clk,
   input  logic                   clr_bar,
   controller_sequencer_if.master ctrl
);

   logic [RING_LENGTH-1:0]       t_state;
   logic [INSTRUCTION_WIDTH-1:0] opcode;
   logic                         halted;
   logic                         hlt_c;
   control_word_t                cw;

   assign opcode = ctrl.instruction_bus;

   ring_counter #(
      .RING_LENGTH (RING_LENGTH)
   ) u_ring (
      .clk     (clk),
      .clr_bar (clr_bar),
      .hold    (hlt_c),
      .t_state (t_state)
   );

   // Halted flag: set on the falling edge that ends an HLT T4, cleared only
   // by reset. Once set it alone keeps hlt high and the ring frozen.
   always_ff @(negedge clk or negedge clr_bar) begin
      if (!clr_bar) begin
         halted <= 1'b0;
      end else if (hlt_c) begin
         halted <= 1'b1;
      end
   end

   // Decode. clr_bar is used directly so the outputs go inactive the moment
   // reset is asserted rather than showing the T1 fetch word.
   always_comb begin
      cw    = CW_IDLE;
      hlt_c = 1'b0;
      if (!clr_bar) begin
         cw    = CW_IDLE;
      end else if (halted) begin
         hlt_c = 1'b1;
      end else if (t_state[T1]) begin
         cw.Ep     = 1'b1;
         cw.Lm_bar = 1'b0;
      end else if (t_state[T2]) begin
         cw.Cp     = 1'b1;
      end else if (t_state[T3]) begin
         cw.CE_bar = 1'b0;
         cw.Li_bar = 1'b0;
      end else if (t_state[T4]) begin
         case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
               cw.Ei_bar = 1'b0;
               cw.Lm_bar = 1'b0;
            end
            OP_OUT: begin
               cw.Ea     = 1'b1;
               cw.Lo_bar = 1'b0;
            end
            OP_HLT: hlt_c = 1'b1;
            default: ;
         endcase
      end else if (t_state[T5]) begin
         case (opcode)
            OP_LDA: begin
               cw.CE_bar = 1'b0;
               cw.La_bar = 1'b0;
            end
            OP_ADD, OP_SUB: begin
               cw.CE_bar = 1'b0;
               cw.Lb_bar = 1'b0;
            end
            default: ;
         endcase
      end else if (t_state[T6]) begin
         case (opcode)
            OP_ADD: begin
               cw.Eu     = 1'b1;
               cw.La_bar = 1'b0;
            end
            OP_SUB: begin
               cw.Eu     = 1'b1;
               cw.La_bar = 1'b0;
               cw.Su     = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign ctrl.t_state = t_state;
   assign ctrl.Cp      = cw.Cp;
   assign ctrl.Ep      = cw.Ep;
   assign ctrl.Lm_bar  = cw.Lm_bar;
   assign ctrl.CE_bar  = cw.CE_bar;
   assign ctrl.Li_bar  = cw.Li_bar;
   assign ctrl.Ei_bar  = cw.Ei_bar;
   assign ctrl.La_bar  = cw.La_bar;
   assign ctrl.Ea      = cw.Ea;
   assign ctrl.Su      = cw.Su;
   assign ctrl.Eu      = cw.Eu;
   assign ctrl.Lb_bar  = cw.Lb_bar;
   assign ctrl.Lo_bar  = cw.Lo_bar;
   assign ctrl.hlt     = hlt_c;

   // At most one W-bus driver may be active when the datapath samples.
   bus_contention: assert property (
      @(posedge clk)
      $countones({cw.Ep, ~cw.CE_bar, ~cw.Ei_bar, cw.Ea, cw.Eu}) <= 1
   );

endmodule

// File: tb/tb_controller_sequencer.sv
// ----------------------------------------------------------------------------
// tb_controller_sequencer
// Table-driven directed checks of every instruction's T1..T6 control word,
// hand-written halt and mid-instruction reset sequences, and a randomized run
// compared against a behavioural model of the SAP-1 sequencing rules.
// ----------------------------------------------------------------------------
module tb_controller_sequencer;
   import sap1_pkg::*;

   // Expected control words as raw levels (Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo)
   localparam logic [11:0] W_IDLE   = 12'b001111100011;
   localparam logic [11:0] W_T1     = 12'b010111100011;
   localparam logic [11:0] W_T2     = 12'b101111100011;
   localparam logic [11:0] W_T3     = 12'b001001100011;
   localparam logic [11:0] W_MEM_T4 = 12'b000110100011;
   localparam logic [11:0] W_LDA_T5 = 12'b001011000011;
   localparam logic [11:0] W_ADD_T5 = 12'b001011100001;
   localparam logic [11:0] W_ADD_T6 = 12'b001111000111;
   localparam logic [11:0] W_SUB_T6 = 12'b001111001111;
   localparam logic [11:0] W_OUT_T4 = 12'b001111110010;

   // Active-sense masks used by the reference model
   localparam logic [11:0] M_CP = 12'h800, M_EP = 12'h400, M_LM = 12'h200,
                           M_CE = 12'h100, M_LI = 12'h080, M_EI = 12'h040,
                           M_LA = 12'h020, M_EA = 12'h010, M_SU = 12'h008,
                           M_EU = 12'h004, M_LB = 12'h002, M_LO = 12'h001;

   logic clk = 1'b0;
   logic clr_bar = 1'b0;

   controller_sequencer_if ifc ();

   controller_sequencer dut (
      .clk     (clk),
      .clr_bar (clr_bar),
      .ctrl    (ifc)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0]  op;
      logic [5:0]  t;
      logic [11:0] cw;
      logic        h;
   } vec_t;
   vec_t tbl[$];

   function automatic logic [11:0] dut_cw();
      return {ifc.Cp, ifc.Ep, ifc.Lm_bar, ifc.CE_bar, ifc.Li_bar, ifc.Ei_bar,
              ifc.La_bar, ifc.Ea, ifc.Su, ifc.Eu, ifc.Lb_bar, ifc.Lo_bar};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string name, input logic [5:0] t, input logic [11:0] cw, input logic h);
      chk({name, "_t"},   32'(ifc.t_state), 32'(t));
      chk({name, "_cw"},  32'(dut_cw()),    32'(cw));
      chk({name, "_hlt"}, 32'(ifc.hlt),     32'(h));
   endtask

   task automatic add_seq(input logic [3:0] op, input logic [11:0] c4,
                          input logic [11:0] c5, input logic [11:0] c6);
      tbl.push_back('{op, 6'b000001, W_T1, 1'b0});
      tbl.push_back('{op, 6'b000010, W_T2, 1'b0});
      tbl.push_back('{op, 6'b000100, W_T3, 1'b0});
      tbl.push_back('{op, 6'b001000, c4,   1'b0});
      tbl.push_back('{op, 6'b010000, c5,   1'b0});
      tbl.push_back('{op, 6'b100000, c6,   1'b0});
   endtask

   // Reset pulse placed between edges; returns just after release, in T1.
   task automatic do_reset();
      @(negedge clk);
      #1 clr_bar = 1'b0;
      #2 clr_bar = 1'b1;
   endtask

   // Reference model: T-state as an integer 0..5 plus a halted bit.
   int m_t;
   bit m_halt;

   function automatic logic [12:0] model_out(input logic [3:0] op, input int t, input bit halted);
      logic [11:0] act;
      logic        h;
      act = '0;
      h   = 1'b0;
      if (halted) h = 1'b1;
      else begin
         case (t)
            0: act = M_EP | M_LM;
            1: act = M_CP;
            2: act = M_CE | M_LI;
            3: begin
               if (op == 4'd0 || op == 4'd1 || op == 4'd2) act = M_EI | M_LM;
               else if (op == 4'hE) act = M_EA | M_LO;
               else if (op == 4'hF) h = 1'b1;
            end
            4: begin
               if (op == 4'd0) act = M_CE | M_LA;
               else if (op == 4'd1 || op == 4'd2) act = M_CE | M_LB;
            end
            5: begin
               if (op == 4'd1) act = M_EU | M_LA;
               else if (op == 4'd2) act = M_EU | M_LA | M_SU;
            end
            default: ;
         endcase
      end
      // active-low lines invert: the idle word marks exactly those positions
      return {h, act ^ W_IDLE};
   endfunction

   initial begin
      logic [12:0] exp;
      int          halt_cycles;

      ifc.instruction_bus = 4'b0000;

      // ---------------- reset state ----------------
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      chk_all("reset", 6'b000001, W_IDLE, 1'b0);

      add_seq(OP_LDA, W_MEM_T4, W_LDA_T5, W_IDLE);
      add_seq(OP_ADD, W_MEM_T4, W_ADD_T5, W_ADD_T6);
      add_seq(OP_SUB, W_MEM_T4, W_ADD_T5, W_SUB_T6);
      add_seq(OP_OUT, W_OUT_T4, W_IDLE,   W_IDLE);
      add_seq(4'b0111, W_IDLE,  W_IDLE,   W_IDLE);

      // release just after a falling edge: the next falling edge gives T2
      @(negedge clk);
      #1 clr_bar = 1'b1;

      // ---------------- table-driven instruction cycles ----------------
      foreach (tbl[i]) begin
         ifc.instruction_bus = tbl[i].op;
         @(posedge clk); #1;
         chk_all($sformatf("tbl%0d", i), tbl[i].t, tbl[i].cw, tbl[i].h);
         @(negedge clk); #1;
      end
      @(posedge clk); #1;
      chk("wrap_to_t1", 32'(ifc.t_state), 32'h1);

      // ---------------- halt ----------------
      do_reset();
      ifc.instruction_bus = OP_HLT;
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      chk_all("halt_t4", 6'b001000, W_IDLE, 1'b1);
      @(negedge clk); #1;
      ifc.instruction_bus = 4'b0000;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         chk_all($sformatf("halted%0d", k), 6'b001000, W_IDLE, 1'b1);
      end
      #1 clr_bar = 1'b0;
      #1 chk_all("halt_clr", 6'b000001, W_IDLE, 1'b0);
      #1 clr_bar = 1'b1;

      // ---------------- mid-instruction reset ----------------
      do_reset();
      ifc.instruction_bus = OP_ADD;
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      chk_all("add_t5", 6'b010000, W_ADD_T5, 1'b0);
      #1 clr_bar = 1'b0;
      #1 chk_all("async_clr", 6'b000001, W_IDLE, 1'b0);
      #1 clr_bar = 1'b1;

      // ---------------- randomized run against the model ----------------
      do_reset();
      m_t = 0;
      m_halt = 1'b0;
      halt_cycles = 0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (m_halt || (m_t == 3 && ifc.instruction_bus == 4'hF)) m_halt = 1'b1;
         else m_t = (m_t + 1) % 6;
         #1;
         // favour the defined opcodes, but also exercise NOPs
         case ($urandom_range(0, 7))
            0: ifc.instruction_bus = 4'h0;
            1: ifc.instruction_bus = 4'h1;
            2: ifc.instruction_bus = 4'h2;
            3: ifc.instruction_bus = 4'hE;
            4: ifc.instruction_bus = ($urandom_range(0, 3) == 0) ? 4'hF : 4'h1;
            default: ifc.instruction_bus = 4'($urandom_range(0, 15));
         endcase
         halt_cycles = m_halt ? halt_cycles + 1 : 0;
         if ($urandom_range(0, 39) == 0 || halt_cycles > 8) begin
            clr_bar = 1'b0;
            m_t = 0;
            m_halt = 1'b0;
            halt_cycles = 0;
            #1 chk_all($sformatf("rnd_clr%0d", n), 6'b000001, W_IDLE, 1'b0);
            #1 clr_bar = 1'b1;
         end
         @(posedge clk); #1;
         exp = model_out(ifc.instruction_bus, m_t, m_halt);
         chk_all($sformatf("rnd%0d", n), 6'(1 << m_t), exp[11:0], exp[12]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/controller_sequencer.md
Name: controller_sequencer

Overview:
- Control unit for the SAP-1 datapath, and the consumer of the 4-bit opcode presented by the instruction register.
- Runs a 6-state one-hot ring counter (T1..T6) through the fetch cycle (T1-T3) and the execute cycle (T4-T6).
- Decodes the opcode together with the current T-state into the 12-bit control word (Cp Ep Lm_bar CE_bar Li_bar Ei_bar La_bar Ea Su Eu Lb_bar Lo_bar) and the halt signal that drive every other block.

Parameters:
INSTRUCTION_WIDTH, 4, width of instruction_bus (opcode)
RING_LENGTH, 6, number of T-states; fixed at 6 for SAP-1, other values are unsupported

Ports:
clk  input  1  system clock; the state register updates on the falling edge
clr_bar  input  1  asynchronous active-low reset
instruction_bus  input  INSTRUCTION_WIDTH  opcode from instruction register
t_state  output  RING_LENGTH  one-hot current T-state; bit0 = T1
Cp  output  1  program counter increment (active-high)
Ep  output  1  program counter enable onto W bus (active-high)
Lm_bar  output  1  MAR load (active-low)
CE_bar  output  1  RAM enable onto W bus (active-low)
Li_bar  output  1  instruction register load (active-low)
Ei_bar  output  1  instruction register operand enable (active-low)
La_bar  output  1  accumulator load (active-low)
Ea  output  1  accumulator enable onto W bus (active-high)
Su  output  1  adder/subtracter subtract select (active-high)
Eu  output  1  adder/subtracter enable onto W bus (active-high)
Lb_bar  output  1  B register load (active-low)
Lo_bar  output  1  output register load (active-low)
hlt  output  1  halt request to the clock generator (active-high)

Behaviour:
Reset:
- While clr_bar=0: t_state=000001 (T1), halted flag=0, hlt=0.
- While clr_bar=0, every control output is at its inactive level: active-low outputs =1, active-high outputs =0.
- Release of clr_bar is not registered. The first falling edge after release moves T1 to T2.
- Reset asserted mid-instruction returns immediately to T1, clears halt, and forces all control outputs inactive.

Sequencing:
- The ring advances T1 to T2 to ... to T6 to T1 on each falling clk edge, so the control word is stable one half-period before each rising edge, where the datapath loads.
- The decode is purely combinational from t_state and instruction_bus. There are no extra pipeline stages.
- An instruction takes 6 clocks.

Control word per state (only the listed signals are active; all others inactive):
- T1: Ep, Lm_bar.
- T2: Cp.
- T3: CE_bar, Li_bar.
- T4-T6 by opcode:
  - LDA 0000: T4 Ei_bar, Lm_bar; T5 CE_bar, La_bar; T6 none.
  - ADD 0001: T4 Ei_bar, Lm_bar; T5 CE_bar, Lb_bar; T6 Eu, La_bar.
  - SUB 0010: same as ADD, plus Su in T6 only.
  - OUT 1110: T4 Ea, Lo_bar; T5 none; T6 none.
  - HLT 1111: see Halt below.
  - Any other opcode: NOP, no signals in T4-T6.

Halt:
- In T4 with opcode 1111, hlt=1 combinationally and no other signal is active.
- At the next falling edge the halted flag sets and the ring does not advance; it holds T4.
- While halted: hlt=1, all other control outputs inactive, instruction_bus changes ignored.
- Only clr_bar=0 exits the halted state.

Bus-contention invariant:
- At most one W-bus driver (Ep, CE_bar active, Ei_bar active, Ea, Eu) is active in any state.
- A simulation assertion checks this invariant.

Decomposition:
- Package sap1_pkg holds:
  - opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT;
  - a T-state index enum T1..T6;
  - a packed control_word_t struct in the bit order given in Overview;
  - a localparam CW_IDLE holding all-inactive levels.
- One sub-module, ring_counter: one-hot shift with async active-low reset to T1, a negedge clock, and a hold input (driven by halt).
- Decode is an always_comb case in controller_sequencer.

Test Plan:
- Reset: clr_bar=0 for 3 clocks with instruction_bus=0000 -> t_state=000001, control word = CW_IDLE, hlt=0. On release, the first falling edge gives t_state=000010.
- Fetch plus LDA: instruction_bus=0000 across T1..T6 ->
  - T1: Ep=1, Lm_bar=0;
  - T2: Cp=1;
  - T3: CE_bar=0, Li_bar=0;
  - T4: Ei_bar=0, Lm_bar=0;
  - T5: CE_bar=0, La_bar=0;
  - T6: CW_IDLE;
  - then back to T1 (000001).
- ADD vs SUB: opcode 0001 then 0010 -> T5 Lb_bar=0. T6 Eu=1, La_bar=0, with Su=0 for ADD and Su=1 for SUB. Su=0 in every other state.
- OUT and NOP: opcode 1110 -> T4 Ea=1, Lo_bar=0. Opcode 0111 -> CW_IDLE in T4-T6, and the ring completes the cycle to T1.
- Halt: opcode 1111 -> hlt=1 in T4. t_state stays 001000 for 10 further clocks with hlt=1 and the rest CW_IDLE, even if instruction_bus changes to 0000. Then clr_bar pulse -> T1, hlt=0.
- Mid-instruction reset: assert clr_bar asynchronously (between edges) during T5 of ADD -> outputs go to CW_IDLE and t_state=000001 immediately, without waiting for a clock edge. Run the contention assertion throughout all tests.
